// File: rtl/riscv_pkg.sv
// Shared constants and types for the load/store unit: memory-op encodings,
// address-region bases and the LSU state type.
package riscv_pkg;

  localparam int FUNCT3_W = 3;

  localparam logic [FUNCT3_W-1:0] MEM_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] MEM_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] MEM_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] MEM_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] MEM_HU = 3'b101;

  localparam logic [15:0] REGION_ROM  = 16'h0000;
  localparam logic [15:0] REGION_MMIO = 16'h7000;
  localparam logic [15:0] REGION_RAM  = 16'h8000;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_PEND,
    LSU_SECOND
  } lsu_state_t;

  function automatic logic region_mapped(input logic [15:0] addr_hi);
    return (addr_hi == REGION_ROM) || (addr_hi == REGION_MMIO) || (addr_hi == REGION_RAM);
  endfunction

  // Half at byte 3 or word off a word boundary spills into the next word.
  function automatic logic needs_second_beat(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == 2'd1) && (addr_lo == 2'd3)) || ((size == 2'd2) && (addr_lo != 2'd0));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory port bundle for the load/store unit.
// slave = the LSU itself; master = the pipeline plus memory it talks to.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_store_data;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;

  logic [31:0] dmem_address;
  logic        dmem_enable;
  logic        dmem_write_enable;
  logic [2:0]  dmem_write_mode;
  logic [31:0] dmem_write_data;
  logic        dmem_read_enable;
  logic [2:0]  dmem_read_mode;
  logic [31:0] dmem_read_data;
  logic        dmem_wait;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_address, req_store_data, req_rd,
    output req_ready,
    output resp_valid, resp_rd, resp_data,
    output dmem_address, dmem_enable, dmem_write_enable, dmem_write_mode, dmem_write_data,
    output dmem_read_enable, dmem_read_mode,
    input  dmem_read_data, dmem_wait
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_address, req_store_data, req_rd,
    input  req_ready,
    input  resp_valid, resp_rd, resp_data,
    input  dmem_address, dmem_enable, dmem_write_enable, dmem_write_mode, dmem_write_data,
    input  dmem_read_enable, dmem_read_mode,
    output dmem_read_data, dmem_wait
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of lane-aligned load data according to funct3.
// Unknown encodings pass the raw word through untouched.
module lsu_load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw_data,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = raw_data;
    case (funct3)
      MEM_B:   ext_data = {{24{raw_data[7]}}, raw_data[7:0]};
      MEM_BU:  ext_data = {24'h0, raw_data[7:0]};
      MEM_H:   ext_data = {{16{raw_data[15]}}, raw_data[15:0]};
      MEM_HU:  ext_data = {16'h0, raw_data[15:0]};
      default: ext_data = raw_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: issues ops to the data memory, tracks the
// outstanding load, extends its result, flags unmapped accesses and counts ops.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  load_store_unit_if.slave bus,
  output logic             fault,
  output logic [CNT_W-1:0] load_count,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] unaligned_count
);

  lsu_state_t       state_q, state_d;
  logic [2:0]       pend_funct3_q, pend_funct3_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic             pend_fault_q, pend_fault_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] load_count_q, load_count_d;
  logic [CNT_W-1:0] store_count_q, store_count_d;
  logic [CNT_W-1:0] unaligned_count_q, unaligned_count_d;

  logic        accept;
  logic        accept_load;
  logic        unmapped;
  logic        unaligned;
  logic        resp_valid;
  logic [31:0] ext_data;

  assign bus.req_ready = reset_n && !bus.dmem_wait;
  assign accept        = bus.req_valid && bus.req_ready;
  assign accept_load   = accept && !bus.req_is_store;
  assign unmapped      = !region_mapped(bus.req_address[31:16]);
  assign unaligned     = needs_second_beat(bus.req_funct3[1:0], bus.req_address[1:0]);

  assign bus.dmem_enable       = accept;
  assign bus.dmem_write_enable = accept && bus.req_is_store;
  assign bus.dmem_read_enable  = accept_load;
  assign bus.dmem_address      = bus.req_address;
  assign bus.dmem_write_mode   = bus.req_funct3;
  assign bus.dmem_read_mode    = bus.req_funct3;
  assign bus.dmem_write_data   = bus.req_store_data;

  lsu_load_extend u_extend (
    .funct3   (pend_funct3_q),
    .raw_data (bus.dmem_read_data),
    .ext_data (ext_data)
  );

  assign bus.resp_valid = resp_valid;
  assign bus.resp_rd    = pend_rd_q;
  assign bus.resp_data  = pend_fault_q ? 32'h0 : ext_data;

  assign fault           = fault_q;
  assign load_count      = load_count_q;
  assign store_count     = store_count_q;
  assign unaligned_count = unaligned_count_q;

  always_comb begin
    state_d    = state_q;
    resp_valid = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (accept_load) state_d = LSU_PEND;
      end
      LSU_PEND: begin
        if (bus.dmem_wait) begin
          state_d = LSU_SECOND;
        end else begin
          resp_valid = 1'b1;
          state_d    = accept_load ? LSU_PEND : LSU_IDLE;
        end
      end
      LSU_SECOND: begin
        // Memory guarantees the wait lasts a single cycle, so data is here now.
        resp_valid = 1'b1;
        state_d    = accept_load ? LSU_PEND : LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
    if (!reset_n) resp_valid = 1'b0;
  end

  always_comb begin
    pend_funct3_d     = pend_funct3_q;
    pend_rd_d         = pend_rd_q;
    pend_fault_d      = pend_fault_q;
    fault_d           = accept && unmapped;
    load_count_d      = load_count_q;
    store_count_d     = store_count_q;
    unaligned_count_d = unaligned_count_q;
    if (accept) begin
      pend_funct3_d = bus.req_funct3;
      pend_rd_d     = bus.req_rd;
      pend_fault_d  = unmapped;
      if (bus.req_is_store) store_count_d = store_count_q + CNT_W'(1);
      else                  load_count_d  = load_count_q + CNT_W'(1);
      if (unaligned) unaligned_count_d = unaligned_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q           <= LSU_IDLE;
      pend_funct3_q     <= 3'b0;
      pend_rd_q         <= 5'b0;
      pend_fault_q      <= 1'b0;
      fault_q           <= 1'b0;
      load_count_q      <= '0;
      store_count_q     <= '0;
      unaligned_count_q <= '0;
    end else begin
      state_q           <= state_d;
      pend_funct3_q     <= pend_funct3_d;
      pend_rd_q         <= pend_rd_d;
      pend_fault_q      <= pend_fault_d;
      fault_q           <= fault_d;
      load_count_q      <= load_count_d;
      store_count_q     <= store_count_d;
      unaligned_count_q <= unaligned_count_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-addressed memory environment,
// directed cases plus randomized traffic against a byte-level reference model.
module tb_load_store_unit;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        fault;
  logic [31:0] load_count;
  logic [31:0] store_count;
  logic [31:0] unaligned_count;

  load_store_unit_if bus();

  load_store_unit #(.CNT_W(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus),
    .fault           (fault),
    .load_count      (load_count),
    .store_count     (store_count),
    .unaligned_count (unaligned_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t       sb[$];
  bit         exp_fault[int];
  bit [7:0]   env_mem[bit [31:0]];
  bit [7:0]   ref_mem[bit [31:0]];
  int         n_load, n_store, n_unal;
  int         unal_at = -1;

  logic [2:0] legal_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0] bad_f3[3]   = '{3'b011, 3'b110, 3'b111};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit mapped(input logic [31:0] a);
    return a[31:16] == 16'h0000 || a[31:16] == 16'h7000 || a[31:16] == 16'h8000;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit spills(input logic [2:0] f3, input logic [31:0] a);
    return (f3[1:0] == 2'd1 && a[1:0] == 2'd3) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic bit [7:0] rget(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic bit [7:0] eget(input bit [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : 8'h00;
  endfunction

  // Expected architectural load result from the reference byte memory.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (!mapped(a)) return 32'h0;
    for (int i = 0; i < nbytes(f3); i++) v = v + (32'(rget(a + 32'(i))) << (8 * i));
    if (f3 == 3'b000 && v >= 32'd128)   v = v - 32'd256;
    if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  task automatic preload_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      env_mem[a + 32'(i)] = w[8*i +: 8];
      ref_mem[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  // Memory environment: one-cycle read latency, one wait cycle on a spill.
  always @(posedge clk) begin
    if (!reset_n) begin
      bus.dmem_wait      <= 1'b0;
      bus.dmem_read_data <= 32'h0;
    end else begin
      bus.dmem_wait <= 1'b0;
      if (bus.dmem_enable) begin
        if (bus.dmem_write_enable) begin
          if (spills(bus.dmem_write_mode, bus.dmem_address)) bus.dmem_wait <= 1'b1;
          if (mapped(bus.dmem_address))
            for (int i = 0; i < nbytes(bus.dmem_write_mode); i++)
              env_mem[bus.dmem_address + 32'(i)] = bus.dmem_write_data[8*i +: 8];
        end
        if (bus.dmem_read_enable) begin
          logic [31:0] rv;
          rv = 32'h0;
          if (spills(bus.dmem_read_mode, bus.dmem_address)) bus.dmem_wait <= 1'b1;
          for (int i = 0; i < nbytes(bus.dmem_read_mode); i++)
            rv[8*i +: 8] = eget(bus.dmem_address + 32'(i));
          bus.dmem_read_data <= mapped(bus.dmem_address) ? rv : 32'hBAD0_BAD0;
        end
      end
    end
  end

  task automatic model_accept(input bit st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input logic [4:0] rd);
    exp_t e;
    exp_fault[cyc + 1] = !mapped(a);
    if (st) begin
      n_store++;
      if (mapped(a))
        for (int i = 0; i < nbytes(f3); i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
    end else begin
      n_load++;
      e.rd   = rd;
      e.data = ref_load(f3, a);
      e.cyc  = cyc + (spills(f3, a) ? 2 : 1);
      sb.push_back(e);
    end
    if (spills(f3, a)) begin
      n_unal++;
      unal_at = cyc + 1;
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd);
    bit acc;
    acc = 1'b0;
    bus.req_valid      = 1'b1;
    bus.req_is_store   = st;
    bus.req_funct3     = f3;
    bus.req_address    = a;
    bus.req_store_data = d;
    bus.req_rd         = rd;
    for (int t = 0; t < 20 && !acc; t++) begin
      check("req_ready", {31'b0, bus.req_ready}, (unal_at == cyc) ? 32'd0 : 32'd1);
      if (bus.req_ready) begin
        model_accept(st, f3, a, d, rd);
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("accept_timeout", {31'b0, acc}, 32'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_load_count"}, load_count, 32'(n_load));
    check({tag, "_store_count"}, store_count, 32'(n_store));
    check({tag, "_unaligned_count"}, unaligned_count, 32'(n_unal));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    exp_fault.delete();
    n_load  = 0;
    n_store = 0;
    n_unal  = 0;
    unal_at = -1;
    idle(2);
    reset_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      check("resp_valid_in_reset", {31'b0, bus.resp_valid}, 32'd0);
      check("fault_in_reset", {31'b0, fault}, 32'd0);
    end else begin
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", {31'b0, bus.resp_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_rd", {27'b0, bus.resp_rd}, {27'b0, e.rd});
          check("resp_data", bus.resp_data, e.data);
          check("resp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("resp_missing", {31'b0, bus.resp_valid}, 32'd1);
        void'(sb.pop_front());
      end
      if (exp_fault.exists(cyc) || fault)
        check("fault", {31'b0, fault}, exp_fault.exists(cyc) ? {31'b0, exp_fault[cyc]} : 32'd0);
    end
  end

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [15:0] hi;
    int          r;

    n_load = 0; n_store = 0; n_unal = 0;
    reset_n            = 1'b0;
    bus.req_valid      = 1'b1;
    bus.req_is_store   = 1'b0;
    bus.req_funct3     = 3'b010;
    bus.req_address    = 32'h8000_0000;
    bus.req_store_data = 32'h0;
    bus.req_rd         = 5'd1;
    preload_word(32'h8000_0010, 32'hDEAD_BEEF);
    idle(3);
    check("reset_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("reset_dmem_enable", {31'b0, bus.dmem_enable}, 32'd0);
    check("reset_read_enable", {31'b0, bus.dmem_read_enable}, 32'd0);
    check_counts("reset");
    bus.req_valid = 1'b0;
    reset_n       = 1'b1;
    idle(1);

    do_op(0, 3'b010, 32'h8000_0010, 32'h0, 5'd5);
    idle(2);
    check_counts("lw");

    do_op(1, 3'b000, 32'h8000_0013, 32'h0000_0080, 5'd0);
    do_op(0, 3'b000, 32'h8000_0013, 32'h0, 5'd6);
    do_op(0, 3'b100, 32'h8000_0013, 32'h0, 5'd7);
    do_op(1, 3'b001, 32'h8000_0020, 32'h0000_FFFF, 5'd0);
    do_op(0, 3'b001, 32'h8000_0020, 32'h0, 5'd8);
    do_op(0, 3'b101, 32'h8000_0020, 32'h0, 5'd9);
    idle(2);

    do_op(0, 3'b010, 32'h8000_0001, 32'h0, 5'd10);
    do_op(0, 3'b010, 32'h8000_0008, 32'h0, 5'd11);
    idle(2);
    check_counts("unaligned");

    do_op(1, 3'b010, 32'h8000_0004, 32'h1234_5678, 5'd0);
    do_op(0, 3'b010, 32'h8000_0004, 32'h0, 5'd12);
    do_op(0, 3'b010, 32'h4000_0000, 32'h0, 5'd13);
    do_op(0, 3'b011, 32'h8000_0010, 32'h0, 5'd14);
    idle(2);
    check_counts("store_fault");

    // Unaligned load, then reset while its second beat is being returned.
    do_op(0, 3'b010, 32'h8000_0002, 32'h0, 5'd15);
    idle(1);
    do_reset();
    check_counts("post_reset");
    idle(3);

    for (int n = 0; n < 300; n++) begin
      st = ($urandom_range(0, 3) == 0);
      if (st) f3 = legal_f3[$urandom_range(0, 2)];
      else if ($urandom_range(0, 19) < 18) f3 = legal_f3[$urandom_range(0, 4)];
      else f3 = bad_f3[$urandom_range(0, 2)];
      r = $urandom_range(0, 9);
      if (r < 7)       hi = 16'h8000;
      else if (r == 7) hi = 16'h0000;
      else if (r == 8) hi = 16'h7000;
      else             hi = ($urandom_range(0, 1) == 0) ? 16'h4000 : 16'hFFFF;
      a = {hi, 10'h0, 6'($urandom_range(0, 63))};
      do_op(st, f3, a, $urandom, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(6);
    check_counts("final");
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
